// File: rtl/program_loader.sv
// Boot-time program loader: receives a length-prefixed, XOR-checksummed byte
// stream and writes it as big-endian 32-bit words into instruction memory.
module program_loader #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned TIMEOUT    = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int unsigned CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int unsigned WL_W      = ADDR_WIDTH + 1;
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [7:0]         cnt_hi;
    logic [15:0]        n_words;
    logic [23:0]        shift;
    logic [1:0]         byte_idx;
    logic [7:0]         csum;
    logic [CNT_W-1:0]   idle_cnt;

    logic               accept;
    logic               active;
    logic               sess_start;
    logic               last_word;
    logic               timed_out;
    logic [15:0]        count_full;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        accept     = in_valid && in_ready;
        active     = (state == S_CNT_HI) || (state == S_CNT_LO) ||
                     (state == S_DATA)   || (state == S_CHK);
        sess_start = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
        count_full = {cnt_hi, in_byte};
        last_word  = (32'(words_loaded) + 32'd1) == 32'(n_words);
        timed_out  = (idle_cnt == CNT_W'(TIMEOUT - 1));

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (sess_start) state_next = S_CNT_HI;
            end
            S_CNT_HI: begin
                if (accept) state_next = S_CNT_LO;
            end
            S_CNT_LO: begin
                if (accept) begin
                    if (count_full == 16'd0)                state_next = S_CHK;
                    else if (32'(count_full) > MAX_WORDS)  state_next = S_ERR;
                    else                                   state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && (byte_idx == 2'd3) && last_word) state_next = S_CHK;
            end
            S_CHK: begin
                if (accept) state_next = (in_byte == csum) ? S_DONE : S_ERR;
            end
            default: state_next = S_IDLE;
        endcase

        if (active && !accept && timed_out) state_next = S_ERR;
    end

    // Datapath and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            cnt_hi       <= '0;
            n_words      <= '0;
            shift        <= '0;
            byte_idx     <= '0;
            csum         <= '0;
            idle_cnt     <= '0;
        end else begin
            imem_we  <= 1'b0;
            in_ready <= (state_next == S_CNT_HI) || (state_next == S_CNT_LO) ||
                        (state_next == S_DATA)   || (state_next == S_CHK);
            cpu_hold <= (state_next == S_CNT_HI) || (state_next == S_CNT_LO) ||
                        (state_next == S_DATA)   || (state_next == S_CHK) ||
                        (state_next == S_ERR);
            error    <= (state_next == S_ERR);
            done     <= (state_next == S_DONE) && (state != S_DONE);

            if (accept || !active) idle_cnt <= '0;
            else                   idle_cnt <= idle_cnt + CNT_W'(1);

            if (sess_start) begin
                words_loaded <= '0;
                csum         <= '0;
                byte_idx     <= '0;
                idle_cnt     <= '0;
            end

            if (accept && (state == S_CNT_HI)) cnt_hi  <= in_byte;
            if (accept && (state == S_CNT_LO)) n_words <= count_full;

            // Assemble big-endian words; issue the write on the 4th byte
            if (accept && (state == S_DATA)) begin
                shift    <= {shift[15:0], in_byte};
                byte_idx <= byte_idx + 2'd1;
                csum     <= csum ^ in_byte;
                if (byte_idx == 2'd3) begin
                    imem_we      <= 1'b1;
                    imem_addr    <= words_loaded[ADDR_WIDTH-1:0];
                    imem_wdata   <= {shift, in_byte};
                    words_loaded <= words_loaded + WL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: good/bad checksums,
// oversize count, timeout, mid-word reset, empty program and start filtering.
`timescale 1ns/1ps
module tb_program_loader;

    localparam int unsigned AW = 14;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_byte;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    int            done_cnt;

    program_loader #(.ADDR_WIDTH(AW), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
        .in_byte(in_byte), .in_ready(in_ready), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
        .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clock = ~clock;

    // Record write strobes and done pulses mid-cycle
    always @(negedge clock) begin
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one byte and return #1 after the edge that accepts it
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited   = 0;
        in_byte  = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL send_byte: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
        end
        tick();
    endtask

    task automatic send_stream(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        repeat (3) tick();
        checks++;
        if ({in_ready, imem_we, cpu_hold, done, error} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b required 00000",
                     {in_ready, imem_we, cpu_hold, done, error});
        end
        checks++;
        if ({words_loaded, imem_addr, imem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_data: words=%0d addr=%0h wdata=%08h required 0",
                     words_loaded, imem_addr, imem_wdata);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] hdr[$];
        logic [7:0] rest[$];
        clear_log();
        pulse_start();
        checks++;
        if ({in_ready, cpu_hold} !== 2'b11) begin
            failures++;
            $display("FAIL basic_session_open: ready,hold=%b required 11", {in_ready, cpu_hold});
        end
        hdr = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h10};
        foreach (hdr[i]) send_byte(hdr[i]);
        checks++;
        if ({imem_we, in_ready, imem_addr, imem_wdata} !== {2'b11, 14'd0, 32'h3C010010}) begin
            failures++;
            $display("FAIL basic_write_cycle: we=%b ready=%b addr=%0h data=%08h required 1 1 0 3c010010",
                     imem_we, in_ready, imem_addr, imem_wdata);
        end
        send_byte(8'h08);
        checks++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b0, 14'd0, 32'h3C010010}) begin
            failures++;
            $display("FAIL basic_hold: we=%b addr=%0h data=%08h required 0 0 3c010010",
                     imem_we, imem_addr, imem_wdata);
        end
        // checksum = 3C^01^00^10^08^00^00^00 = 25
        rest = '{8'h00, 8'h00, 8'h00, 8'h25};
        send_stream(rest);
        tick(); tick();
        checks++;
        if (wr_addr.size() != 2 || wr_addr[0] !== 14'd0 || wr_data[0] !== 32'h3C010010 ||
            wr_addr[1] !== 14'd1 || wr_data[1] !== 32'h08000000) begin
            failures++;
            $display("FAIL basic_writes: count=%0d required 2 (0:3c010010, 1:08000000)", wr_addr.size());
        end
        checks++;
        if (done_cnt != 1 || words_loaded !== 15'd2 || cpu_hold !== 1'b0 || error !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL basic_done: pulses=%0d words=%0d hold=%b err=%b done=%b required 1 2 0 0 0",
                     done_cnt, words_loaded, cpu_hold, error, done);
        end
    endtask

    task automatic test_bad_checksum();
        logic [7:0] s[$];
        clear_log();
        pulse_start();
        s = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h10, 8'h08, 8'h00, 8'h00, 8'h00, 8'h35};
        send_stream(s);
        tick(); tick();
        checks++;
        if (done_cnt != 0 || error !== 1'b1 || cpu_hold !== 1'b1 || words_loaded !== 15'd2 || wr_addr.size() != 2) begin
            failures++;
            $display("FAIL bad_checksum: pulses=%0d err=%b hold=%b words=%0d writes=%0d required 0 1 1 2 2",
                     done_cnt, error, cpu_hold, words_loaded, wr_addr.size());
        end
    endtask

    task automatic test_oversize();
        logic [7:0] s[$];
        clear_log();
        pulse_start();
        s = '{8'h40, 8'h01};
        send_stream(s);
        checks++;
        if (error !== 1'b1 || in_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            failures++;
            $display("FAIL oversize_abort: err=%b ready=%b hold=%b required 1 0 1", error, in_ready, cpu_hold);
        end
        repeat (6) tick();
        checks++;
        if (wr_addr.size() != 0) begin
            failures++;
            $display("FAIL oversize_nowrite: writes=%0d required 0", wr_addr.size());
        end
        // exactly 2^ADDR_WIDTH words is legal
        pulse_start();
        s = '{8'h40, 8'h00};
        send_stream(s);
        checks++;
        if (error !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL max_count_accepted: err=%b ready=%b required 0 1", error, in_ready);
        end
        reset = 1'b1; tick(); reset = 1'b0;
    endtask

    task automatic test_timeout();
        logic [7:0] s[$];
        clear_log();
        pulse_start();
        s = '{8'h00, 8'h01, 8'h3C, 8'h01};
        send_stream(s);
        repeat (15) tick();
        checks++;
        if (error !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early: err=%b after 15 idle cycles required 0", error);
        end
        tick();
        checks++;
        if (error !== 1'b1 || cpu_hold !== 1'b1 || wr_addr.size() != 0) begin
            failures++;
            $display("FAIL timeout_abort: err=%b hold=%b writes=%0d required 1 1 0",
                     error, cpu_hold, wr_addr.size());
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] s[$];
        clear_log();
        pulse_start();
        s = '{8'h00, 8'h01, 8'h3C, 8'h01, 8'h00};
        foreach (s[i]) send_byte(s[i]);
        start = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0; in_valid = 1'b0;
        checks++;
        if ({in_ready, imem_we, cpu_hold, done, error, words_loaded, imem_addr, imem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_mid_word: ready=%b we=%b hold=%b done=%b err=%b words=%0d addr=%0h data=%08h required all 0",
                     in_ready, imem_we, cpu_hold, done, error, words_loaded, imem_addr, imem_wdata);
        end
        tick();
        pulse_start();
        // checksum = DE^AD^BE^EF = 22
        s = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        send_stream(s);
        tick(); tick();
        checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 14'd0 || wr_data[0] !== 32'hDEADBEEF || done_cnt != 1 || error !== 1'b0) begin
            failures++;
            $display("FAIL reload_after_reset: writes=%0d pulses=%0d err=%b required 1 write 0:deadbeef, 1 pulse, err 0",
                     wr_addr.size(), done_cnt, error);
        end
    endtask

    task automatic test_zero_words();
        logic [7:0] s[$];
        clear_log();
        pulse_start();
        s = '{8'h00, 8'h00, 8'h00};
        send_stream(s);
        tick(); tick();
        checks++;
        if (done_cnt != 1 || wr_addr.size() != 0 || words_loaded !== 15'd0 || error !== 1'b0 || cpu_hold !== 1'b0) begin
            failures++;
            $display("FAIL zero_words: pulses=%0d writes=%0d words=%0d err=%b hold=%b required 1 0 0 0 0",
                     done_cnt, wr_addr.size(), words_loaded, error, cpu_hold);
        end
    endtask

    task automatic test_start_ignored();
        logic [7:0] s[$];
        clear_log();
        pulse_start();
        s = '{8'h00, 8'h02, 8'h11, 8'h22};
        send_stream(s);
        pulse_start();
        // checksum = 11^22^33^44^55^66^77^88 = 88
        s = '{8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
        send_stream(s);
        tick(); tick();
        checks++;
        if (wr_addr.size() != 2 || wr_data[0] !== 32'h11223344 || wr_addr[1] !== 14'd1 ||
            wr_data[1] !== 32'h55667788 || done_cnt != 1 || words_loaded !== 15'd2) begin
            failures++;
            $display("FAIL start_ignored: writes=%0d pulses=%0d words=%0d required 2 (11223344, 55667788) 1 2",
                     wr_addr.size(), done_cnt, words_loaded);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s[$];
        clear_log();
        pulse_start();
        checks++;
        if (words_loaded !== 15'd0 || cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL restart_from_done: words=%0d hold=%b ready=%b required 0 1 1",
                     words_loaded, cpu_hold, in_ready);
        end
        s = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        send_stream(s);
        tick(); tick();
        checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 14'd0 || wr_data[0] !== 32'h01020304 || done_cnt != 1) begin
            failures++;
            $display("FAIL back_to_back: writes=%0d pulses=%0d required 1 write 0:01020304, 1 pulse",
                     wr_addr.size(), done_cnt);
        end
    endtask

    initial begin
        done_cnt = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_bad_checksum();
        test_oversize();
        test_timeout();
        test_reset_mid_word();
        test_zero_words();
        test_start_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
